// File: rtl/vram_arbiter.sv
// Shared VRAM arbiter: one byte-wide CPU port and NUM_RD word read ports.
// Define VRAM_ARB_RR_EN for round-robin read ports (default: fixed priority).
module vram_arbiter #(
  parameter int NUM_RD      = 3,
  parameter int ADDR_W      = 15,
  parameter int CPU_MAX_RUN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W+1:0]        cpu_addr,
  input  logic [7:0]               cpu_wrdata,
  input  logic                     cpu_strobe,
  input  logic                     cpu_write,
  output logic                     cpu_ack,
  output logic [7:0]               cpu_rddata,
  output logic                     cpu_stall,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_strobe,
  output logic [NUM_RD-1:0]        rd_ack,
  output logic [31:0]              rd_rddata
);

  localparam int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam logic [3:0] RUN_MAX = 4'(CPU_MAX_RUN);

  logic [3:0]        r_run;
  logic              w_any_rd;
  logic              w_force;
  logic              w_cpu_gnt;
  logic              w_rd_gnt;
  logic              w_found;
  logic [IDX_W-1:0]  w_idx;
  logic [ADDR_W-1:0] w_rd_a;
  logic [ADDR_W-1:0] w_ram_a;
  logic [NUM_RD-1:0] w_rd_oh;
  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_q;
  logic              r_cpu_ack;
  logic              r_cpu_rd;
  logic [1:0]        r_lane;
  logic [7:0]        r_hold;
  logic [7:0]        w_byte;
  logic [NUM_RD-1:0] r_rd_ack;

  assign w_any_rd  = |rd_strobe;
  assign w_force   = w_any_rd && (r_run == RUN_MAX);
  assign w_cpu_gnt = !rst && cpu_strobe && !w_force;
  assign w_rd_gnt  = !rst && !w_cpu_gnt && w_found;
  assign cpu_stall = cpu_strobe && !w_cpu_gnt;

`ifdef VRAM_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;

  // Descending scan so the requester closest above r_ptr wins.
  always_comb begin
    logic [IDX_W:0] c;
    w_found = 1'b0;
    w_idx   = '0;
    c       = '0;
    for (int k = NUM_RD - 1; k >= 0; k--) begin
      c = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (c >= (IDX_W+1)'(NUM_RD))
        c = c - (IDX_W+1)'(NUM_RD);
      if (rd_strobe[c[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = c[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_rd_gnt)
      r_ptr <= (w_idx == IDX_W'(NUM_RD - 1)) ? '0 : w_idx + 1'b1;
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = NUM_RD - 1; k >= 0; k--) begin
      if (rd_strobe[k]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    w_rd_oh = '0;
    w_rd_a  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (w_idx == IDX_W'(k))
        w_rd_a = rd_addr[k*ADDR_W +: ADDR_W];
    end
    if (w_rd_gnt)
      w_rd_oh[w_idx] = 1'b1;
  end

  assign w_ram_a = w_cpu_gnt ? cpu_addr[ADDR_W+1:2] : w_rd_a;

  always_ff @(posedge clk) begin
    if (w_cpu_gnt && cpu_write)
      r_mem[w_ram_a][{cpu_addr[1:0], 3'b000} +: 8] <= cpu_wrdata;
    r_q <= r_mem[w_ram_a];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_ack <= 1'b0;
      r_cpu_rd  <= 1'b0;
      r_lane    <= '0;
      r_rd_ack  <= '0;
      r_hold    <= '0;
      r_run     <= '0;
    end else begin
      r_cpu_ack <= w_cpu_gnt;
      r_cpu_rd  <= w_cpu_gnt && !cpu_write;
      r_lane    <= cpu_addr[1:0];
      r_rd_ack  <= w_rd_oh;
      r_hold    <= cpu_rddata;
      if (w_rd_gnt || !cpu_strobe)
        r_run <= '0;
      else if (w_cpu_gnt && w_any_rd && r_run != RUN_MAX)
        r_run <= r_run + 4'd1;
    end
  end

  // Outputs are gated by rst so an ack due during reset never escapes.
  assign w_byte     = r_q[{r_lane, 3'b000} +: 8];
  assign cpu_ack    = r_cpu_ack && !rst;
  assign cpu_rddata = rst ? '0 : (r_cpu_ack && r_cpu_rd) ? w_byte : r_hold;
  assign rd_ack     = rst ? '0 : r_rd_ack;
  assign rd_rddata  = r_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed scoreboard bench for vram_arbiter (default parameters).
// Honors VRAM_ARB_RR_EN for the read-port grant pattern.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] ca;
  logic [7:0]  cd;
  logic        cs;
  logic        cw;
  logic        cpu_ack;
  logic [7:0]  cpu_rddata;
  logic        cpu_stall;
  logic [44:0] ra;
  logic [2:0]  rs;
  logic [2:0]  rd_ack;
  logic [31:0] rd_rddata;

  typedef struct {
    string       tag;
    logic        stall;
    logic        ack;
    logic [7:0]  rdb;
    logic [2:0]  rack;
    logic [31:0] rdd;
    logic [31:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [2:0] pat [4];

  vram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (ca),
    .cpu_wrdata (cd),
    .cpu_strobe (cs),
    .cpu_write  (cw),
    .cpu_ack    (cpu_ack),
    .cpu_rddata (cpu_rddata),
    .cpu_stall  (cpu_stall),
    .rd_addr    (ra),
    .rd_strobe  (rs),
    .rd_ack     (rd_ack),
    .rd_rddata  (rd_rddata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic ak,
                      input logic [7:0] rb, input logic [2:0] rk,
                      input logic [31:0] rd, input logic [31:0] mk);
    exp_t e;
    e.tag = tag; e.stall = st; e.ack = ak; e.rdb = rb;
    e.rack = rk; e.rdd = rd; e.mask = mk;
    sb.push_back(e);
    #1;
    chk({tag, ".stall"}, 32'(cpu_stall), 32'(sb[$].stall));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".ack"}, 32'(cpu_ack), 32'(e.ack));
    chk({e.tag, ".cpu_rd"}, 32'(cpu_rddata), 32'(e.rdb));
    chk({e.tag, ".rd_ack"}, 32'(rd_ack), 32'(e.rack));
    if (e.mask != 32'h0)
      chk({e.tag, ".rd_data"}, rd_rddata & e.mask, e.rdd & e.mask);
    @(negedge clk);
  endtask

  initial begin
`ifdef VRAM_ARB_RR_EN
    pat[0] = 3'b001; pat[1] = 3'b010; pat[2] = 3'b100; pat[3] = 3'b001;
`else
    pat[0] = 3'b001; pat[1] = 3'b001; pat[2] = 3'b001; pat[3] = 3'b001;
`endif
    rst = 1'b1; cs = 1'b0; cw = 1'b0; ca = '0; cd = '0; rs = '0; ra = '0;
    @(negedge clk);
    step("rst0", 0, 0, 8'h00, 3'b000, 0, 0);
    step("rst1", 0, 0, 8'h00, 3'b000, 0, 0);

    rst = 1'b0; cs = 1'b1; cw = 1'b1; ca = 17'h6; cd = 8'hA5;
    step("wr_a5", 0, 1, 8'h00, 3'b000, 0, 0);
    cw = 1'b0;
    step("rd_a5", 0, 1, 8'hA5, 3'b000, 0, 0);
    cs = 1'b0; rs = 3'b001; ra[0 +: 15] = 15'h1;
    step("p0_w1", 0, 0, 8'hA5, 3'b001, 32'h00A5_0000, 32'h00FF_0000);
    rs = 3'b000; cs = 1'b1; cw = 1'b1; ca = 17'h7; cd = 8'h11;
    step("wr_11", 0, 1, 8'hA5, 3'b000, 0, 0);

    cw = 1'b0; ca = 17'h6; rs = 3'b010; ra[15 +: 15] = 15'h1;
    for (int i = 0; i < 9; i++) begin
      if (i == 4)
        step("run_p1", 1, 0, 8'hA5, 3'b010, 32'h11A5_0000, 32'hFFFF_0000);
      else
        step("run_cpu", 0, 1, 8'hA5, 3'b000, 0, 0);
    end

    cs = 1'b0; rs = 3'b000; rst = 1'b1;
    step("rst2", 0, 0, 8'h00, 3'b000, 0, 0);
    rst = 1'b0; rs = 3'b111;
    for (int i = 0; i < 4; i++)
      step("all_rd", 0, 0, 8'h00, pat[i], 0, 0);

    cs = 1'b1; cw = 1'b1; ca = 17'h40; cd = 8'h3C;
    rs = 3'b100; ra[30 +: 15] = 15'h10;
    step("wr_3c", 0, 1, 8'h00, 3'b000, 0, 0);
    cs = 1'b0;
    step("p2_3c", 0, 0, 8'h00, 3'b100, 32'h0000_003C, 32'h0000_00FF);

    rs = 3'b001; ra[0 +: 15] = 15'h10; cs = 1'b1; cw = 1'b0; ca = 17'h40;
    step("cpu_vs_p0", 0, 1, 8'h3C, 3'b000, 0, 0);
    rs = 3'b000; cs = 1'b0;
    step("p0_drop", 0, 0, 8'h3C, 3'b000, 0, 0);

    cs = 1'b1; cw = 1'b0; ca = 17'h40;
    #1;
    chk("rst_rd.stall", 32'(cpu_stall), 32'h0);
    @(posedge clk);
    rst = 1'b1; cs = 1'b0;
    #1;
    chk("rst_rd.ack", 32'(cpu_ack), 32'h0);
    chk("rst_rd.cpu_rd", 32'(cpu_rddata), 32'h0);
    chk("rst_rd.rd_ack", 32'(rd_ack), 32'h0);
    @(negedge clk);
    step("rst3", 0, 0, 8'h00, 3'b000, 0, 0);
    rst = 1'b0; cs = 1'b1; ca = 17'h40;
    step("rd_kept", 0, 1, 8'h3C, 3'b000, 0, 0);
    cs = 1'b0;
    step("idle", 0, 0, 8'h3C, 3'b000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
